// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: streams program words from instruction
// memory port 2 into a small prefetch FIFO, delivered on a valid/ready stream.
// Optional feature macro: INSTR_FETCH_PERF_CNT_EN (delivered-word counter).
module instr_fetch_unit #(
  parameter int         ADDR_W      = 10,
  parameter int         DATA_W      = 32,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_last,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       perf_fetch_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;

  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;

  logic issue, capture, pop, flush, start_acc, credit, cap_halt;

  assign credit   = (32'(count_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
  assign cap_halt = (mem_readdata[DATA_W-1 -: 4] == HALT_OPCODE);

  // Next-state, issue and FIFO control; abort overrides capture, issue and pop.
  // Returns are only captured in FETCH, so a read issued alongside the HALT
  // capture (or before an abort) is dropped without an explicit discard flag.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cap_addr_d = cap_addr_q;
    issue      = 1'b0;
    capture    = 1'b0;
    flush      = 1'b0;
    start_acc  = 1'b0;
    pop        = instr_valid & instr_ready;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          pc_d      = start_addr;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else begin
          capture = inflight_q;
          issue   = credit;
          if (issue) begin
            pc_d       = pc_q + ADDR_W'(1);
            cap_addr_d = pc_q;
          end
          if (capture && cap_halt) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (pop && instr_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) pop = 1'b0;
    inflight_d = issue;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  // Prefetch FIFO storage and pointers; simultaneous push/pop allowed when full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
    end else begin
      if (capture) begin
        fifo_data_q[wr_ptr_q] <= mem_readdata;
        fifo_addr_q[wr_ptr_q] <= cap_addr_q;
        fifo_last_q[wr_ptr_q] <= cap_halt;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({capture, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign instr_valid    = (count_q != '0);
  assign instr_data     = fifo_data_q[rd_ptr_q];
  assign instr_addr     = fifo_addr_q[rd_ptr_q];
  assign instr_last     = fifo_last_q[rd_ptr_q];

  assign busy           = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign mem_chipselect = issue;
  assign mem_address    = pc_q;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  // Delivered-word counter: cleared on accepted start, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    perf_q <= '0;
    else if (start_acc)              perf_q <= '0;
    else if (pop && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_fetch_count = perf_q;
`else
  assign perf_fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a 1-cycle-latency
// instruction memory model (registered address, unregistered q).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  start_addr;
  logic        abort;
  logic        busy, done;
  logic [9:0]  mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic [31:0] instr_data;
  logic [9:0]  instr_addr;
  logic        instr_last, instr_valid, instr_ready;
  logic [31:0] perf_fetch_count;

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch_unit #(
    .ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(4), .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .abort(abort), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
    .instr_data(instr_data), .instr_addr(instr_addr), .instr_last(instr_last),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .perf_fetch_count(perf_fetch_count)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] imem [1024];
  logic [9:0]  raddr_q = '0;
  always @(posedge clk) if (mem_chipselect && mem_clken) raddr_q <= mem_address;
  assign mem_readdata = imem[raddr_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge and clear single-cycle pulses.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Sample each cycle from the current one: check the handshake sequence and
  // stop at the done pulse (left in the done cycle).
  task automatic drain_check(input string tag, input int unsigned first_addr,
                             input int unsigned n_exp);
    int unsigned k = 0;
    bit seen_done = 1'b0;
    logic [9:0] exp_a;
    for (int unsigned c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        check({tag, " busy@done"}, 32'(busy), 32'd0);
      end else if (instr_valid && instr_ready) begin
        exp_a = 10'(first_addr + k);
        check({tag, " addr"}, 32'(instr_addr), 32'(exp_a));
        check({tag, " data"}, instr_data, imem[exp_a]);
        check({tag, " last"}, 32'(instr_last), 32'(k == n_exp - 1));
        k++;
      end
      if (!seen_done) next_cycle();
    end
    check({tag, " count"}, k, n_exp);
    check({tag, " done seen"}, 32'(seen_done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},   32'(busy), 32'd0);
    check({tag, " done"},   32'(done), 32'd0);
    check({tag, " valid"},  32'(instr_valid), 32'd0);
    check({tag, " cs"},     32'(mem_chipselect), 32'd0);
    check({tag, " maddr"},  32'(mem_address), 32'd0);
    check({tag, " idata"},  instr_data, 32'd0);
    check({tag, " iaddr"},  32'(instr_addr), 32'd0);
    check({tag, " ilast"},  32'(instr_last), 32'd0);
    check({tag, " perf"},   perf_fetch_count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cs;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h2000_0000 | 32'(i);
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; instr_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    check("rst clken", 32'(mem_clken), 32'd1);
    check("rst write", 32'(mem_write), 32'd0);
    check("rst be",    32'(mem_byteenable), 32'hF);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Test 1: five-word program with HALT at 4, cycle-exact timing
    for (int i = 0; i < 4; i++) imem[i] = 32'h1000_0000 | 32'(i);
    imem[4] = 32'hF000_0000;
    next_cycle(); start = 1'b1; start_addr = 10'd0; instr_ready = 1'b1;
    @(negedge clk);
    check("t1 c0 busy", 32'(busy), 32'd0);
    next_cycle(); @(negedge clk);
    check("t1 c1 cs", 32'(mem_chipselect), 32'd1);
    check("t1 c1 maddr", 32'(mem_address), 32'd0);
    check("t1 c1 busy", 32'(busy), 32'd1);
    next_cycle(); @(negedge clk);
    check("t1 c2 maddr", 32'(mem_address), 32'd1);
    check("t1 c2 valid", 32'(instr_valid), 32'd0);
    for (int c = 3; c <= 7; c++) begin
      next_cycle(); @(negedge clk);
      check("t1 valid", 32'(instr_valid), 32'd1);
      check("t1 addr", 32'(instr_addr), 32'(c - 3));
      check("t1 data", instr_data, imem[c - 3]);
      check("t1 last", 32'(instr_last), 32'(c == 7));
      check("t1 done early", 32'(done), 32'd0);
    end
    next_cycle(); @(negedge clk);
    check("t1 c8 done", 32'(done), 32'd1);
    check("t1 c8 busy", 32'(busy), 32'd0);
    check("t1 c8 valid", 32'(instr_valid), 32'd0);
    next_cycle(); @(negedge clk);
    check("t1 c9 done", 32'(done), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    check("t1 perf", perf_fetch_count, 32'd5);
`else
    check("t1 perf", perf_fetch_count, 32'd0);
`endif

    // Test 2: backpressure, exactly FIFO_DEPTH reads then stall
    next_cycle(); start = 1'b1; start_addr = 10'd0; instr_ready = 1'b0;
    n_cs = 0;
    for (int c = 1; c <= 12; c++) begin
      next_cycle(); @(negedge clk);
      if (mem_chipselect) n_cs++;
      if (c >= 3) begin
        check("t2 hold valid", 32'(instr_valid), 32'd1);
        check("t2 hold addr", 32'(instr_addr), 32'd0);
        check("t2 hold data", instr_data, 32'h1000_0000);
      end
    end
    check("t2 reads", n_cs, 32'd4);
    check("t2 cs idle", 32'(mem_chipselect), 32'd0);
    next_cycle(); instr_ready = 1'b1;
    drain_check("t2", 0, 5);

    // Test 3: HALT at 1023 with address wrap
    imem[1021] = 32'h3000_03FD;
    imem[1022] = 32'h3000_03FE;
    imem[1023] = 32'hF000_03FF;
    next_cycle(); start = 1'b1; start_addr = 10'd1021;
    next_cycle();
    drain_check("t3", 1021, 3);

    // Test 4: abort mid-run, then restart elsewhere
    imem[4]   = 32'h2000_0004;
    imem[102] = 32'hF000_0066;
    next_cycle(); start = 1'b1; start_addr = 10'd0;
    for (int c = 1; c <= 5; c++) next_cycle();
    abort = 1'b1;
    @(negedge clk);
    check("t4 c6 valid", 32'(instr_valid), 32'd1);
    check("t4 c6 done", 32'(done), 32'd0);
    next_cycle(); @(negedge clk);
    check("t4 c7 valid", 32'(instr_valid), 32'd0);
    check("t4 c7 busy", 32'(busy), 32'd0);
    check("t4 c7 done", 32'(done), 32'd0);
    check("t4 c7 cs", 32'(mem_chipselect), 32'd0);
    next_cycle(); start = 1'b1; start_addr = 10'd100;
    @(negedge clk);
    check("t4 c8 done", 32'(done), 32'd0);
    next_cycle(); @(negedge clk);
    check("t4 c9 cs", 32'(mem_chipselect), 32'd1);
    check("t4 c9 maddr", 32'(mem_address), 32'd100);
    drain_check("t4", 100, 3);

    // Test 5: HALT at start_addr; start ignored while busy and in DONE
    imem[7] = 32'hF123_4567;
    next_cycle(); start = 1'b1; start_addr = 10'd7;
    next_cycle(); start = 1'b1; start_addr = 10'd50;
    @(negedge clk);
    check("t5 c1 maddr", 32'(mem_address), 32'd7);
    next_cycle(); @(negedge clk);
    check("t5 c2 maddr", 32'(mem_address), 32'd8);
    drain_check("t5", 7, 1);
    start = 1'b1; start_addr = 10'd20;
    next_cycle(); @(negedge clk);
    check("t5 start@done busy", 32'(busy), 32'd0);
    check("t5 start@done cs", 32'(mem_chipselect), 32'd0);

    // Test 6: asynchronous reset with three FIFO entries held
    next_cycle(); start = 1'b1; start_addr = 10'd0; instr_ready = 1'b0;
    for (int c = 1; c <= 5; c++) next_cycle();
    @(negedge clk);
    check("t6 pre valid", 32'(instr_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("t6 async");
    @(posedge clk); #1 reset_n = 1'b1;
    next_cycle(); @(negedge clk);
    check("t6 post busy", 32'(busy), 32'd0);
    check("t6 post valid", 32'(instr_valid), 32'd0);
    check("t6 post cs", 32'(mem_chipselect), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
